// File: rtl/cnet_selectmap_model.sv
// cnet_selectmap_model: synthesizable SelectMAP slave-configuration port emulator.
// Ports:
//   rp_cclk, rp_reset_b          clock (rising edge) and asynchronous active-low reset
//   rp_prog_b, rp_init_b         PROG_B input, INIT_B output (low while clearing or on CRC error)
//   rp_cs_b, rp_rdwr_b, rp_data  beat strobe, direction (1 = read) and write data
//   rp_data_out, rp_data_oe      readback data and its drive enable
//   rp_done                      DONE, high only when idle
//   want_crc_error, expected_sum CRC failure injection and golden checksum
//   cfg_word, cfg_word_vld       last packed 32-bit word and its one-cycle strobe
//   word_count, prog_err         packed-word count and sticky protocol error
module cnet_selectmap_model #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_SWAP   = 1,
    parameter int PROG_B_CNT = 10,
    parameter int INIT_B_CNT = 10,
    parameter int WORD_CNT   = 362185,
    parameter int CRC_CHECK  = 1
) (
    input  logic                  rp_cclk,
    input  logic                  rp_reset_b,
    input  logic                  rp_prog_b,
    output logic                  rp_init_b,
    input  logic                  rp_cs_b,
    input  logic                  rp_rdwr_b,
    input  logic [DATA_WIDTH-1:0] rp_data,
    output logic [DATA_WIDTH-1:0] rp_data_out,
    output logic                  rp_data_oe,
    output logic                  rp_done,
    input  logic                  want_crc_error,
    input  logic [31:0]           expected_sum,
    output logic [31:0]           cfg_word,
    output logic                  cfg_word_vld,
    output logic [31:0]           word_count,
    output logic                  prog_err
);
    localparam int BEATS = 32 / DATA_WIDTH;
    typedef enum logic [2:0] {IDLE, PROG_B, INIT_B, PROG, CRC_ERR} state_t;
    state_t state, state_nxt;
    logic [31:0] cnt, cnt_nxt, part, part_nxt, sum, sum_nxt, sum_new, wc_nxt, cfg_nxt, word;
    logic [DATA_WIDTH-1:0] beat, dout_nxt;
    logic [1:0] idx, idx_nxt;
    logic dir, dir_nxt, vld_nxt, err_nxt, oe_nxt, last;
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++)
            beat[i] = (BIT_SWAP != 0) ? rp_data[DATA_WIDTH-1-i] : rp_data[i];
    end
    // word is the partial word with the current beat merged in at its little-endian slot
    always_comb begin
        word = part;
        word[idx*DATA_WIDTH +: DATA_WIDTH] = beat;
    end
    assign last      = idx == 2'(BEATS - 1);
    assign sum_new   = sum + word;
    assign rp_done   = state == IDLE;
    assign rp_init_b = !(state == PROG_B || state == INIT_B || state == CRC_ERR);
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        part_nxt  = part;
        sum_nxt   = sum;
        wc_nxt    = word_count;
        cfg_nxt   = cfg_word;
        vld_nxt   = 1'b0;
        err_nxt   = prog_err;
        oe_nxt    = 1'b0;
        dout_nxt  = rp_data_out;
        idx_nxt   = idx;
        dir_nxt   = dir;
        if (!rp_prog_b) begin
            // PROG_B dominates everything, including a word completing on this edge
            state_nxt = PROG_B;
            cnt_nxt   = (state != PROG_B) ? 32'(PROG_B_CNT - 1) : (cnt != 0) ? cnt - 1 : cnt;
            part_nxt  = '0;
            sum_nxt   = '0;
            wc_nxt    = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                PROG_B: begin
                    state_nxt = INIT_B;
                    cnt_nxt   = 32'(INIT_B_CNT - 1);
                    err_nxt   = prog_err || (cnt != 0);
                end
                INIT_B: begin
                    state_nxt = (cnt == 0) ? PROG : INIT_B;
                    cnt_nxt   = (cnt == 0) ? cnt : cnt - 1;
                    dir_nxt   = (cnt == 0) ? rp_rdwr_b : dir;
                end
                PROG: if (!rp_cs_b) begin
                    err_nxt = prog_err || (rp_rdwr_b != dir);
                    if (rp_rdwr_b) begin
                        oe_nxt   = 1'b1;
                        dout_nxt = sum[DATA_WIDTH-1:0];
                    end else if (!last) begin
                        part_nxt = word;
                        idx_nxt  = idx + 2'd1;
                    end else begin
                        part_nxt = '0;
                        idx_nxt  = '0;
                        cfg_nxt  = word;
                        vld_nxt  = 1'b1;
                        sum_nxt  = sum_new;
                        wc_nxt   = (word_count != 32'(WORD_CNT)) ? word_count + 1 : word_count;
                        if (wc_nxt == 32'(WORD_CNT))
                            state_nxt = (want_crc_error || (CRC_CHECK != 0 && sum_new != expected_sum)) ? CRC_ERR : IDLE;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge rp_cclk or negedge rp_reset_b) begin
        if (!rp_reset_b) begin
            state        <= IDLE;
            cnt          <= '0;
            part         <= '0;
            sum          <= '0;
            word_count   <= '0;
            cfg_word     <= '0;
            cfg_word_vld <= 1'b0;
            prog_err     <= 1'b0;
            rp_data_oe   <= 1'b0;
            rp_data_out  <= '0;
            idx          <= '0;
            dir          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            part         <= part_nxt;
            sum          <= sum_nxt;
            word_count   <= wc_nxt;
            cfg_word     <= cfg_nxt;
            cfg_word_vld <= vld_nxt;
            prog_err     <= err_nxt;
            rp_data_oe   <= oe_nxt;
            rp_data_out  <= dout_nxt;
            idx          <= idx_nxt;
            dir          <= dir_nxt;
        end
    end
endmodule

// File: tb/tb_cnet_selectmap_model.sv
// tb_cnet_selectmap_model: directed bench for 8-, 32- and 16-bit instances sharing one control bus.
module tb_cnet_selectmap_model;
    logic clk = 1'b0, rst_n = 1'b0, prog_b = 1'b1, cs_b = 1'b1, rdwr_b = 1'b0, want = 1'b0;
    logic [31:0] data = '0, exp_sum = '0;
    int n_chk = 0, n_fail = 0, n;
    logic a_init_b, a_oe, a_done, a_vld, a_err;
    logic [7:0] a_dout;
    logic [31:0] a_cfg, a_wc;
    logic b_init_b, b_oe, b_done, b_vld, b_err;
    logic [31:0] b_dout, b_cfg, b_wc;
    logic c_init_b, c_oe, c_done, c_vld, c_err;
    logic [15:0] c_dout;
    logic [31:0] c_cfg, c_wc;
    logic [7:0] bytes [8] = '{8'h80, 8'h40, 8'hC0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h80};

    always #5 clk = ~clk;

    cnet_selectmap_model #(.DATA_WIDTH(8), .BIT_SWAP(1), .WORD_CNT(2)) u_a (
        .rp_cclk(clk), .rp_reset_b(rst_n), .rp_prog_b(prog_b), .rp_init_b(a_init_b),
        .rp_cs_b(cs_b), .rp_rdwr_b(rdwr_b), .rp_data(data[7:0]), .rp_data_out(a_dout),
        .rp_data_oe(a_oe), .rp_done(a_done), .want_crc_error(want), .expected_sum(exp_sum),
        .cfg_word(a_cfg), .cfg_word_vld(a_vld), .word_count(a_wc), .prog_err(a_err));
    cnet_selectmap_model #(.DATA_WIDTH(32), .BIT_SWAP(0), .WORD_CNT(3)) u_b (
        .rp_cclk(clk), .rp_reset_b(rst_n), .rp_prog_b(prog_b), .rp_init_b(b_init_b),
        .rp_cs_b(cs_b), .rp_rdwr_b(rdwr_b), .rp_data(data), .rp_data_out(b_dout),
        .rp_data_oe(b_oe), .rp_done(b_done), .want_crc_error(want), .expected_sum(exp_sum),
        .cfg_word(b_cfg), .cfg_word_vld(b_vld), .word_count(b_wc), .prog_err(b_err));
    cnet_selectmap_model #(.DATA_WIDTH(16), .BIT_SWAP(0), .WORD_CNT(4)) u_c (
        .rp_cclk(clk), .rp_reset_b(rst_n), .rp_prog_b(prog_b), .rp_init_b(c_init_b),
        .rp_cs_b(cs_b), .rp_rdwr_b(rdwr_b), .rp_data(data[15:0]), .rp_data_out(c_dout),
        .rp_data_oe(c_oe), .rp_done(c_done), .want_crc_error(want), .expected_sum(exp_sum),
        .cfg_word(c_cfg), .cfg_word_vld(c_vld), .word_count(c_wc), .prog_err(c_err));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_pulse(input int cycles);
        prog_b = 1'b0;
        repeat (cycles) tick();
        prog_b = 1'b1;
    endtask

    // counts how many samples INIT_B stays low after PROG_B is released, bounded at 50
    task automatic wait_prog(output int low);
        low = 0;
        tick();
        while (a_init_b == 1'b0 && low < 50) begin
            low++;
            tick();
        end
    endtask

    task automatic wr(input logic [31:0] d);
        cs_b = 1'b0;
        rdwr_b = 1'b0;
        data = d;
        tick();
    endtask

    task automatic wr_stream();
        for (int i = 0; i < 8; i++) wr({24'h0, bytes[i]});
        cs_b = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_done", a_done, 1);
        chk("rst_init_b", a_init_b, 1);
        chk("rst_oe", a_oe, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_cfg", a_cfg, 0);
        chk("rst_vld", a_vld, 0);
        chk("rst_wc", a_wc, 0);
        chk("rst_err", a_err, 0);
        rst_n = 1'b1;
        tick();
        prog_pulse(10);
        chk("progb_init_low", a_init_b, 0);
        chk("progb_done", a_done, 0);
        wait_prog(n);
        chk("init_low_cycles", n, 10);
        chk("prog_done_low", a_done, 0);
        chk("prog_err_clean", a_err, 0);
        exp_sum = 32'h05030201;
        for (int i = 0; i < 4; i++) wr({24'h0, bytes[i]});
        chk("w1_cfg", a_cfg, 32'h04030201);
        chk("w1_vld", a_vld, 1);
        chk("w1_wc", a_wc, 1);
        chk("w1_done", a_done, 0);
        for (int i = 4; i < 8; i++) wr({24'h0, bytes[i]});
        cs_b = 1'b1;
        chk("w2_cfg", a_cfg, 32'h01000000);
        chk("w2_wc", a_wc, 2);
        chk("crc_ok_done", a_done, 1);
        chk("crc_ok_init_b", a_init_b, 1);
        tick();
        chk("vld_one_cycle", a_vld, 0);
        exp_sum = 32'h0;
        prog_pulse(10);
        wait_prog(n);
        wr_stream();
        chk("crc_bad_init_b", a_init_b, 0);
        chk("crc_bad_done", a_done, 0);
        chk("crc_bad_wc", a_wc, 2);
        cs_b = 1'b0;
        rdwr_b = 1'b1;
        tick();
        cs_b = 1'b1;
        rdwr_b = 1'b0;
        chk("crc_err_ignore_err", a_err, 0);
        chk("crc_err_ignore_oe", a_oe, 0);
        prog_pulse(10);
        chk("restart_wc", a_wc, 0);
        chk("restart_init_b", a_init_b, 0);
        wait_prog(n);
        chk("restart_init_cycles", n, 10);
        exp_sum = 32'h05030201;
        want = 1'b1;
        wr_stream();
        chk("want_crc_init_b", a_init_b, 0);
        chk("want_crc_done", a_done, 0);
        want = 1'b0;
        prog_pulse(4);
        wait_prog(n);
        chk("short_progb_err", a_err, 1);
        cs_b = 1'b0;
        rdwr_b = 1'b1;
        tick();
        cs_b = 1'b1;
        rdwr_b = 1'b0;
        chk("toggle_err_sticky", a_err, 1);
        chk("toggle_oe", a_oe, 1);
        chk("toggle_dout", a_dout, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("b_rst_err", b_err, 0);
        prog_pulse(10);
        wait_prog(n);
        wr(32'h11223344);
        cs_b = 1'b1;
        chk("b_w1_cfg", b_cfg, 32'h11223344);
        chk("b_w1_wc", b_wc, 1);
        cs_b = 1'b0;
        rdwr_b = 1'b1;
        tick();
        chk("b_read_oe", b_oe, 1);
        chk("b_read_dout", b_dout, 32'h11223344);
        chk("b_read_dir_err", b_err, 1);
        chk("b_read_wc", b_wc, 1);
        wr(32'h01010101);
        chk("b_w2_wc", b_wc, 2);
        chk("b_w2_oe", b_oe, 0);
        prog_b = 1'b0;
        wr(32'h0000FFFF);
        cs_b = 1'b1;
        prog_b = 1'b1;
        chk("b_progb_wins_init_b", b_init_b, 0);
        chk("b_progb_wins_wc", b_wc, 0);
        chk("b_progb_wins_vld", b_vld, 0);
        chk("b_progb_wins_cfg", b_cfg, 32'h01010101);
        chk("b_progb_wins_done", b_done, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        prog_pulse(10);
        wait_prog(n);
        wr(32'h0001);
        wr(32'h0002);
        chk("c_w1_cfg", c_cfg, 32'h00020001);
        chk("c_w1_wc", c_wc, 1);
        wr(32'h1234);
        data = 32'h5678;
        rst_n = 1'b0;
        #1;
        chk("c_async_wc", c_wc, 0);
        chk("c_async_cfg", c_cfg, 0);
        chk("c_async_vld", c_vld, 0);
        chk("c_async_done", c_done, 1);
        chk("c_async_init_b", c_init_b, 1);
        tick();
        chk("c_rst_no_vld", c_vld, 0);
        chk("c_rst_cfg", c_cfg, 0);
        cs_b = 1'b1;
        rst_n = 1'b1;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
